fc_weight_server: RTL and testbench
===================================

# fc_weight_server

Weight/bias store that answers the fully-connected controller's `weight_addr` requests. It is loaded once from a 16-bit valid/ready word stream, packs the words into `MULT_ADD_UNITS`-lane lines held in on-chip RAM, then serves one registered line per requested address. It also holds the per-output-node biases on a flat bus. It sits between the DMA/host weight stream and the FC datapath.

## Interface
- `DATAWIDTH`, 16: bits per weight/bias word.
- `MULT_ADD_UNITS`, 16: lanes per served line.
- `INPUT_NODES`, 784: inputs per output node; must be a multiple of `MULT_ADD_UNITS`.
- `OUTPUT_NODES`, 2: number of output nodes.
- `ADDR_W`, 7: width of `weight_addr`.
- Derived: `LINES_PER_NODE = INPUT_NODES/MULT_ADD_UNITS` (49). `LINES = LINES_PER_NODE*OUTPUT_NODES` (98). `LINES` must be < 2^`ADDR_W`.

Ports:
- `clk`  in  1: single clock; everything is on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `load_start`  in  1: one-cycle pulse that begins or restarts a load.
- `s_data`  in  `DATAWIDTH`: stream word.
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: block accepts a word.
- `weight_addr`  in  `ADDR_W`: line request from the FC controller.
- `weights`  out  `DATAWIDTH*MULT_ADD_UNITS`: served line.
- `bias`  out  `DATAWIDTH*OUTPUT_NODES`: bias of node n in bits `[DATAWIDTH*n +: DATAWIDTH]`.
- `loaded`  out  1: the store holds a complete, accepted image.
- `load_err`  out  1: checksum mismatch on the last load (see Configuration).

## Operation
- FSM states: IDLE, LOAD_W, LOAD_B, (LOAD_CK), SERVE.
- IDLE:
  - `s_ready`=0 and `loaded`=0.
  - `load_start` moves to LOAD_W.
- LOAD_W:
  - `s_ready`=1. A word transfers on a cycle where `s_valid && s_ready`.
  - Lane counter `k` runs 0..`MULT_ADD_UNITS`-1. Word k is placed in lane bits `[DATAWIDTH*k +: DATAWIDTH]`, so the first word goes to the lowest lane.
  - On the last lane, the assembled line is written to RAM at line counter `a`, then `a` increments.
  - Line order: node 0 lines 0..48 occupy addresses 0..48; node 1 lines occupy 49..97. This matches the controller's `node*LINES_PER_NODE + rounds` addressing.
  - After line `LINES`-1 is written, move to LOAD_B.
- LOAD_B:
  - Accepts `OUTPUT_NODES` words into bias registers, node 0 first.
  - Then moves to LOAD_CK if the checksum is enabled, otherwise to SERVE.
- SERVE:
  - `s_ready`=0 and `loaded`=1.
  - Stream words are not accepted.
- Restart: `load_start` in any state (including mid-load) clears `loaded` and `load_err`, zeroes the counters, and enters LOAD_W. Previously stored lines are overwritten as the new load proceeds.
- Read path:
  - `weights` is a register.
  - When `loaded`=1 and `weight_addr` < `LINES`, it takes RAM[`weight_addr`].
  - Otherwise (the idle sentinel 99, any address ≥ `LINES`, or not loaded) it takes all zeros.
- `bias` is driven from the bias registers only while `loaded`=1, and is 0 otherwise.

## Timing
- Reset values: `s_ready`=0, `weights`=0, `bias`=0, `loaded`=0, `load_err`=0. FSM in IDLE; counters 0; bias registers 0. RAM contents are not reset.
- Read latency is one cycle: an address presented at edge t appears on `weights` after edge t+1. The controller's one-cycle start delay covers this.
- Writes to RAM and reads from RAM never collide, because reads are gated off while `loaded`=0.
- `loaded` rises on the edge that accepts the final word of a load. This is the last bias word, or the checksum word when the checksum is enabled.
- `load_start` has priority over a word transfer in the same cycle; that word is discarded.
- Throughput: one word per cycle. A full load takes `LINES*MULT_ADD_UNITS + OUTPUT_NODES` = 1570 transfers (+1 with the checksum).
- `reset` asserted mid-load aborts immediately to the reset values.

## Configuration
- Macro: `FC_WSRV_CHECKSUM_EN`.
- When defined:
  - A 16-bit wrapping sum of every weight and bias word is accumulated during the load.
  - LOAD_CK accepts one extra word and compares it to the sum.
  - On a match, the FSM enters SERVE with `load_err`=0.
  - On a mismatch, the FSM returns to IDLE with `load_err`=1 and `loaded`=0.
- When undefined:
  - There is no LOAD_CK state and no extra word.
  - `load_err` is tied 0.

## Test plan
- Reset, then drive `weight_addr`=0 → `weights`=0, `bias`=0, `loaded`=0, `s_ready`=0.
- Load with word i = i[15:0], biases 0x3C00 and 0x4000, holding `s_valid` high → `loaded` rises after transfer 1570. Addr 0 returns lanes 0x0000..0x000F, lane 0 in the low bits. Addr 49 returns 0x0310..0x031F. `bias`=0x4000_3C00.
- After the load, present addr 5 then 99 on consecutive cycles → line 5 appears one cycle later, then zeros on the next cycle.
- Toggle `s_valid` randomly during the load → stored image is identical to the back-to-back case; `s_ready` stays 1 until done.
- Pulse `load_start` after 300 words, then load a full image of 0x1111 words → `loaded` clears immediately. After completion every lane reads 0x1111.
- With `FC_WSRV_CHECKSUM_EN` defined, send a correct sum → `loaded`=1. Send sum+1 → `load_err`=1, `loaded`=0, and addr 0 reads zeros.

Source files
------------

// File: rtl/fc_weight_server.sv
// Weight/bias store for the FC controller: packs a 16-bit word stream into lane lines in RAM
// and serves one registered line per weight_addr. Optional load checksum: FC_WSRV_CHECKSUM_EN.
module fc_weight_server #(
  parameter int unsigned DATAWIDTH      = 16,
  parameter int unsigned MULT_ADD_UNITS = 16,
  parameter int unsigned INPUT_NODES    = 784,
  parameter int unsigned OUTPUT_NODES   = 2,
  parameter int unsigned ADDR_W         = 7
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load_start,
  input  logic [DATAWIDTH-1:0]                s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [ADDR_W-1:0]                   weight_addr,
  output logic [DATAWIDTH*MULT_ADD_UNITS-1:0] weights,
  output logic [DATAWIDTH*OUTPUT_NODES-1:0]   bias,
  output logic                                loaded,
  output logic                                load_err
);

  localparam int unsigned LINES_PER_NODE = INPUT_NODES / MULT_ADD_UNITS;
  localparam int unsigned LINES          = LINES_PER_NODE * OUTPUT_NODES;
  localparam int unsigned LINE_W         = DATAWIDTH * MULT_ADD_UNITS;
  localparam int unsigned KW = (MULT_ADD_UNITS > 1) ? $clog2(MULT_ADD_UNITS) : 1;
  localparam int unsigned BW = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1;
  localparam logic [KW-1:0]     K_LAST    = KW'(MULT_ADD_UNITS - 1);
  localparam logic [ADDR_W-1:0] A_LAST    = ADDR_W'(LINES - 1);
  localparam logic [ADDR_W-1:0] A_LIMIT   = ADDR_W'(LINES);
  localparam logic [BW-1:0]     B_LAST    = BW'(OUTPUT_NODES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StLoadB,
`ifdef FC_WSRV_CHECKSUM_EN
    StLoadCk,
`endif
    StServe
  } state_e;

  state_e                 state_q;
  logic [KW-1:0]          k_q;
  logic [ADDR_W-1:0]      a_q;
  logic [BW-1:0]          b_q;
  logic [LINE_W-1:0]      line_q;
  logic [LINE_W-1:0]      line_next;
  logic [DATAWIDTH*OUTPUT_NODES-1:0] bias_q;
  logic [LINE_W-1:0]      mem [LINES];
  logic                   xfer;
  logic                   ram_we;
`ifdef FC_WSRV_CHECKSUM_EN
  logic [DATAWIDTH-1:0]   sum_q;
`endif

  assign xfer   = s_valid & s_ready;
  // load_start wins over a same-cycle transfer, so that word must not reach RAM
  assign ram_we = xfer & ~load_start & (state_q == StLoadW) & (k_q == K_LAST);
  assign bias   = loaded ? bias_q : '0;

  always_comb begin
    line_next = line_q;
    line_next[DATAWIDTH*k_q +: DATAWIDTH] = s_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      s_ready  <= 1'b0;
      loaded   <= 1'b0;
      load_err <= 1'b0;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      line_q   <= '0;
      bias_q   <= '0;
`ifdef FC_WSRV_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else if (load_start) begin
      state_q  <= StLoadW;
      s_ready  <= 1'b1;
      loaded   <= 1'b0;
      load_err <= 1'b0;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
`ifdef FC_WSRV_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
`ifdef FC_WSRV_CHECKSUM_EN
      if (xfer) sum_q <= sum_q + s_data;
`endif
      unique case (state_q)
        StLoadW: begin
          if (xfer) begin
            line_q <= line_next;
            k_q    <= k_q + KW'(1);
            if (k_q == K_LAST) begin
              k_q <= '0;
              a_q <= a_q + ADDR_W'(1);
              if (a_q == A_LAST) state_q <= StLoadB;
            end
          end
        end
        StLoadB: begin
          if (xfer) begin
            bias_q[DATAWIDTH*b_q +: DATAWIDTH] <= s_data;
            b_q <= b_q + BW'(1);
            if (b_q == B_LAST) begin
`ifdef FC_WSRV_CHECKSUM_EN
              state_q <= StLoadCk;
`else
              state_q <= StServe;
              s_ready <= 1'b0;
              loaded  <= 1'b1;
`endif
            end
          end
        end
`ifdef FC_WSRV_CHECKSUM_EN
        StLoadCk: begin
          if (xfer) begin
            s_ready <= 1'b0;
            if (s_data == sum_q) begin
              state_q <= StServe;
              loaded  <= 1'b1;
            end else begin
              state_q  <= StIdle;
              load_err <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[a_q] <= line_next;
  end

  // Reads are gated by loaded, so they never overlap the write phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weights <= '0;
    end else if (loaded && (weight_addr < A_LIMIT)) begin
      weights <= mem[weight_addr];
    end else begin
      weights <= '0;
    end
  end

endmodule

// File: tb/tb_fc_weight_server.sv
// Directed bench for fc_weight_server: ramp and fill loads, restarts, read gating.
module tb_fc_weight_server;

  localparam int NW = 1568;
`ifdef FC_WSRV_CHECKSUM_EN
  localparam int TOTAL = NW + 3;
`else
  localparam int TOTAL = NW + 2;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         load_start;
  logic [15:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [6:0]   weight_addr;
  logic [255:0] weights;
  logic [31:0]  bias;
  logic         loaded;
  logic         load_err;

  logic [255:0] exp_mem [98];
  logic [31:0]  exp_bias;
  int checks = 0;
  int errors = 0;

  fc_weight_server dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .weight_addr (weight_addr),
    .weights     (weights),
    .bias        (bias),
    .loaded      (loaded),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic valid, input logic [15:0] w);
    load_start = 1'b1;
    s_valid    = valid;
    s_data     = w;
    tick();
    load_start = 1'b0;
    s_valid    = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit rnd);
    if (rnd) begin
      while ($urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        tick();
      end
    end
    s_valid = 1'b1;
    s_data  = w;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic load_image(input bit fill, input bit rnd, input bit bad_ck);
    int          ready_bad;
    int          bias_bad;
    logic [15:0] w;
    logic [15:0] sum;
    ready_bad = 0;
    bias_bad  = 0;
    sum       = '0;
    for (int i = 0; i < TOTAL; i++) begin
      if (i < NW) begin
        w = fill ? 16'h1111 : 16'(i);
        exp_mem[i/16][16*(i%16) +: 16] = w;
      end else if (i < NW + 2) begin
        w = fill ? 16'h1111 : ((i == NW) ? 16'h3C00 : 16'h4000);
        exp_bias[16*(i-NW) +: 16] = w;
      end else begin
        w = sum + 16'(bad_ck);
      end
      sum = sum + w;
      if (i == TOTAL - 1) check("loaded_before_last", loaded, 1'b0);
      if (!s_ready) ready_bad++;
      if (bias != 32'h0) bias_bad++;
      send_word(w, rnd);
    end
    check("ready_during_load", ready_bad, 0);
    check("bias_zero_during_load", bias_bad, 0);
    check("s_ready_after_load", s_ready, 1'b0);
    if (bad_ck) begin
      check("loaded_bad_ck", loaded, 1'b0);
      check("load_err_bad_ck", load_err, 1'b1);
    end else begin
      check("loaded_after_last", loaded, 1'b1);
      check("load_err_clean", load_err, 1'b0);
    end
  endtask

  task automatic read_check(input string tag, input logic [6:0] a, input logic [255:0] exp);
    weight_addr = a;
    tick();
    check(tag, weights, exp);
  endtask

  task automatic scan_all();
    for (int a = 0; a < 98; a++) read_check("line", 7'(a), exp_mem[a]);
    check("bias", bias, exp_bias);
  endtask

  initial begin
    logic [255:0] ramp0;
    reset       = 1'b1;
    load_start  = 1'b0;
    s_data      = '0;
    s_valid     = 1'b0;
    weight_addr = 7'd0;
    #12;
    check("rst_weights", weights, '0);
    check("rst_bias", bias, 32'h0);
    check("rst_loaded", loaded, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    read_check("idle_addr0", 7'd0, '0);
    check("idle_s_ready", s_ready, 1'b0);

    // Back-to-back ramp load
    pulse_start(1'b0, 16'h0);
    check("s_ready_after_start", s_ready, 1'b1);
    load_image(1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 16; l++) ramp0[16*l +: 16] = 16'(l);
    read_check("addr0_ramp", 7'd0, ramp0);
    weight_addr = 7'd49;
    tick();
    check("addr49_lane0", weights[15:0], 16'h0310);
    check("addr49_lane15", weights[255:240], 16'h031F);
    check("bias_ramp", bias, 32'h4000_3C00);
    scan_all();

    // Consecutive addresses: line 5, then idle sentinel
    weight_addr = 7'd5;
    tick();
    check("seq_addr5", weights, exp_mem[5]);
    weight_addr = 7'd99;
    tick();
    check("seq_addr99", weights, '0);
    read_check("addr98_zero", 7'd98, '0);
    read_check("addr127_zero", 7'd127, '0);

    // Same image with gaps in s_valid
    pulse_start(1'b0, 16'h0);
    load_image(1'b0, 1'b1, 1'b0);
    scan_all();

    // Restart from SERVE, abort after 300 words, restart with a same-cycle word that is dropped
    pulse_start(1'b1, 16'h2222);
    check("restart_loaded", loaded, 1'b0);
    check("restart_s_ready", s_ready, 1'b1);
    check("restart_bias", bias, 32'h0);
    read_check("restart_read_zero", 7'd0, '0);
    for (int i = 0; i < 300; i++) send_word(16'hBEEF, 1'b0);
    pulse_start(1'b1, 16'h2222);
    check("restart2_loaded", loaded, 1'b0);
    load_image(1'b1, 1'b0, 1'b0);
    scan_all();

`ifdef FC_WSRV_CHECKSUM_EN
    pulse_start(1'b0, 16'h0);
    load_image(1'b0, 1'b0, 1'b1);
    read_check("bad_ck_read_zero", 7'd0, '0);
    check("bad_ck_bias", bias, 32'h0);
`endif

    // Asynchronous reset mid-load
    pulse_start(1'b0, 16'h0);
    for (int i = 0; i < 10; i++) send_word(16'h5555, 1'b0);
    reset = 1'b1;
    #1;
    check("midreset_loaded", loaded, 1'b0);
    check("midreset_s_ready", s_ready, 1'b0);
    check("midreset_weights", weights, '0);
    tick();
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
